// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int RAM_LAT_MAX = 4;
  // The wait counter is loaded with at most RAM_LAT_MAX-2.
  localparam int CNT_W = $clog2(RAM_LAT_MAX - 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// MEM_ARB_RR_EN selects alternating grants on conflict; otherwise data has fixed priority.
module mem_arb_pick (
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_d,
`endif
  output logic grant_valid,
  output logic grant_d
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // On conflict, grant whichever port was not granted last.
  assign grant_d = d_req & (~i_req | ~last_d);
`else
  assign grant_d = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports.
// Build option MEM_ARB_RR_EN enables round-robin conflict resolution.
// Handshake: a port holds req (and its address/data) until it sees a one-cycle
// ack; rdata is valid only in the ack cycle; stall = req & ~ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_stall,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        dbg_state
);

  state_t           state;
  owner_t           owner;
  logic             rd_q;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid;
  logic             grant_d;

`ifdef MEM_ARB_RR_EN
  owner_t last_own;
`endif

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef MEM_ARB_RR_EN
    .last_d      (last_own == OWN_D),
`endif
    .grant_valid (grant_valid),
    .grant_d     (grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_I;
      rd_q    <= 1'b0;
      cnt     <= '0;
      m_en    <= 1'b0;
      m_we    <= 4'h0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_own <= OWN_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state <= ISSUE;
            m_en  <= 1'b1;
            if (grant_d) begin
              owner   <= OWN_D;
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
              rd_q    <= (d_we == 4'h0);
            end else begin
              owner  <= OWN_I;
              m_addr <= i_addr;
              m_we   <= 4'h0;
              rd_q   <= 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            last_own <= grant_d ? OWN_D : OWN_I;
`endif
          end
        end
        ISSUE: begin
          m_en <= 1'b0;
          m_we <= 4'h0;
          if (!rd_q || RAM_LAT == 1) begin
            state <= DONE;
            i_ack <= (owner == OWN_I);
            d_ack <= (owner == OWN_D);
          end else begin
            cnt   <= CNT_W'(RAM_LAT - 2);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            i_ack <= (owner == OWN_I);
            d_ack <= (owner == OWN_D);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data is forwarded only in the owner's ack cycle, and only for reads.
  assign i_rdata   = (i_ack && rd_q) ? m_rdata : '0;
  assign d_rdata   = (d_ack && rd_q) ? m_rdata : '0;
  assign i_stall   = i_req & ~i_ack;
  assign d_stall   = d_req & ~d_ack;
  assign dbg_state = state;

endmodule
